adc_sample_seq: RTL
===================

ADC_SAMPLE_SEQ -- requirements
Module: adc_sample_seq

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 2500, clocks per audio sample period (minimum 16).
REQ-002 SHALL have parameter AUDIO_CH, default 3'd0, ADC channel carrying the guitar signal.
REQ-003 SHALL have parameter POT_BASE, default 3'd1, first of three consecutive potentiometer channels (POT_BASE..POT_BASE+2).
REQ-004 SHALL have parameter TIMEOUT, default 4095, maximum clocks to wait for cnv_complete.
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  enables sample timer; low holds the timer at 0.
REQ-008 start_cnv  output  1  one-cycle pulse to the SPI ADC interface.
REQ-009 channel  output  3  ADC channel select to the SPI ADC interface.
REQ-010 result  input  12  conversion result, offset binary, valid when cnv_complete high.
REQ-011 cnv_complete  input  1  one-cycle conversion-done pulse from the SPI ADC interface.
REQ-012 audio_sample  output  12  latest audio sample, two's complement.
REQ-013 audio_valid  output  1  one-cycle pulse when audio_sample updates.
REQ-014 pot0, pot1, pot2  output  12 each  latest unsigned pot readings.
REQ-015 overrun  output  1  sticky: a sample tick arrived while not IDLE.
REQ-016 timeout_err  output  1  sticky: a conversion exceeded TIMEOUT clocks.

Function
REQ-017 Timer SHALL count 0..SAMPLE_DIV-1 while en=1 and wrap; tick SHALL be asserted for the one cycle where count equals SAMPLE_DIV-1.
REQ-018 FSM states SHALL be IDLE, AUD_START, AUD_WAIT, POT_START, POT_WAIT.
REQ-019 IDLE -> AUD_START on tick; tick in any other state SHALL be dropped and SHALL set overrun.
REQ-020 AUD_START SHALL drive channel=AUDIO_CH, pulse start_cnv for exactly one cycle, go to AUD_WAIT.
REQ-021 AUD_WAIT on cnv_complete SHALL register audio_sample = {~result[11], result[10:0]}, pulse audio_valid the following cycle, go to POT_START.
REQ-022 POT_START SHALL drive channel=POT_BASE+pot_idx, pulse start_cnv one cycle, go to POT_WAIT.
REQ-023 POT_WAIT on cnv_complete SHALL write result to pot[pot_idx], advance pot_idx 0->1->2->0, go to IDLE.
REQ-024 channel SHALL remain stable from the start_cnv cycle until the matching cnv_complete is observed.
REQ-025 start_cnv SHALL never be asserted in two consecutive cycles; at most one conversion outstanding.
REQ-026 cnv_complete in IDLE, AUD_START or POT_START SHALL be ignored.
REQ-027 Wait counter SHALL clear on entry to AUD_WAIT/POT_WAIT; reaching TIMEOUT SHALL set timeout_err, return to IDLE, leave audio_sample and pot regs unchanged, and not advance pot_idx.
REQ-028 cnv_complete and timeout in the same cycle: cnv_complete SHALL win, timeout_err unchanged.
REQ-029 en deasserted mid-conversion SHALL let the current sequence finish; no new tick until en=1.
REQ-030 Latency tick -> audio_valid SHALL be (ADC conversion clocks) + 3 clocks, constant across samples.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, timer 0, pot_idx 0, start_cnv 0, channel AUDIO_CH, audio_sample 0, audio_valid 0, pot0..pot2 0, overrun 0, timeout_err 0.
REQ-032 Reset mid-conversion SHALL abandon it; a late cnv_complete after release SHALL be ignored per REQ-026.
REQ-033 overrun and timeout_err SHALL clear only by reset.

Verification
REQ-034 SAMPLE_DIV=200, ADC model answers result=12'hA00 after 50 clocks -> audio_sample=12'h200, audio_valid one pulse per 200 clocks, start_cnv channel AUDIO_CH then POT_BASE.
REQ-035 Three sample periods, pot channels return 12'h111/12'h222/12'h333 -> pot0=12'h111, pot1=12'h222, pot2=12'h333, fourth period reads channel POT_BASE again.
REQ-036 Model withholds cnv_complete, TIMEOUT=100 -> timeout_err=1 at wait clock 100, FSM IDLE, next tick starts audio conversion normally.
REQ-037 SAMPLE_DIV=60, conversion 50 clocks -> overrun=1 after first period, no back-to-back start_cnv, sticky until reset.
REQ-038 rst_n pulsed low during AUD_WAIT -> all outputs at reset values immediately; stray cnv_complete after release leaves audio_valid=0.
REQ-039 result=12'h000 and 12'hFFF -> audio_sample=12'h800 (-2048) and 12'h7FF (+2047).

Source files
------------

// File: rtl/adc_sample_seq.sv
// Audio-rate ADC sequencer: one audio conversion plus one round-robin pot conversion per sample period.
// Catches conversions that never complete, and sample ticks that arrive while a sequence is still running.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for the sample tick
// AUD_START | select audio channel, launch conversion
// AUD_WAIT  | waiting for audio cnv_complete or timeout
// POT_START | select pot channel POT_BASE+pot_idx, launch conversion
// POT_WAIT  | waiting for pot cnv_complete or timeout
module adc_sample_seq #(
   parameter int unsigned SAMPLE_DIV = 2500,
   parameter logic [2:0]  AUDIO_CH   = 3'd0,
   parameter logic [2:0]  POT_BASE   = 3'd1,
   parameter int unsigned TIMEOUT    = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        start_cnv,
   output logic [2:0]  channel,
   input  logic [11:0] result,
   input  logic        cnv_complete,
   output logic [11:0] audio_sample,
   output logic        audio_valid,
   output logic [11:0] pot0,
   output logic [11:0] pot1,
   output logic [11:0] pot2,
   output logic        overrun,
   output logic        timeout_err
);

   localparam int TMR_W  = $clog2(SAMPLE_DIV);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      AUD_START,
      AUD_WAIT,
      POT_START,
      POT_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [1:0]        pot_idx_q, pot_idx_d;
   logic              start_cnv_q, start_cnv_d;
   logic [2:0]        channel_q, channel_d;
   logic [11:0]       audio_sample_q, audio_sample_d;
   logic              audio_valid_q, audio_valid_d;
   logic [11:0]       pot0_q, pot0_d;
   logic [11:0]       pot1_q, pot1_d;
   logic [11:0]       pot2_q, pot2_d;
   logic              overrun_q, overrun_d;
   logic              timeout_err_q, timeout_err_d;
   logic              tick;
   logic              wait_last;

   always_comb begin
      tick  = en && (tmr_q == TMR_LAST);
      tmr_d = tmr_q;
      if (!en || tick) begin
         tmr_d = '0;
      end else begin
         tmr_d = tmr_q + TMR_W'(1);
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      pot_idx_d      = pot_idx_q;
      start_cnv_d    = 1'b0;
      channel_d      = channel_q;
      audio_sample_d = audio_sample_q;
      audio_valid_d  = 1'b0;
      pot0_d         = pot0_q;
      pot1_d         = pot1_q;
      pot2_d         = pot2_q;
      overrun_d      = overrun_q | (tick && (state_q != IDLE));
      timeout_err_d  = timeout_err_q;
      wait_last      = (wait_q == WAIT_LAST);

      case (state_q)
         IDLE: begin
            if (tick) state_d = AUD_START;
         end
         AUD_START: begin
            channel_d   = AUDIO_CH;
            start_cnv_d = 1'b1;
            wait_d      = '0;
            state_d     = AUD_WAIT;
         end
         AUD_WAIT: begin
            wait_d = wait_q + WAIT_W'(1);
            // completion takes priority over a timeout landing on the same clock
            if (cnv_complete) begin
               audio_sample_d = {~result[11], result[10:0]};
               audio_valid_d  = 1'b1;
               state_d        = POT_START;
            end else if (wait_last) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         POT_START: begin
            channel_d   = POT_BASE + 3'(pot_idx_q);
            start_cnv_d = 1'b1;
            wait_d      = '0;
            state_d     = POT_WAIT;
         end
         POT_WAIT: begin
            wait_d = wait_q + WAIT_W'(1);
            if (cnv_complete) begin
               case (pot_idx_q)
                  2'd0:    pot0_d = result;
                  2'd1:    pot1_d = result;
                  default: pot2_d = result;
               endcase
               pot_idx_d = (pot_idx_q == 2'd2) ? 2'd0 : pot_idx_q + 2'd1;
               state_d   = IDLE;
            end else if (wait_last) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         tmr_q          <= '0;
         wait_q         <= '0;
         pot_idx_q      <= 2'd0;
         start_cnv_q    <= 1'b0;
         channel_q      <= AUDIO_CH;
         audio_sample_q <= 12'h000;
         audio_valid_q  <= 1'b0;
         pot0_q         <= 12'h000;
         pot1_q         <= 12'h000;
         pot2_q         <= 12'h000;
         overrun_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_q          <= tmr_d;
         wait_q         <= wait_d;
         pot_idx_q      <= pot_idx_d;
         start_cnv_q    <= start_cnv_d;
         channel_q      <= channel_d;
         audio_sample_q <= audio_sample_d;
         audio_valid_q  <= audio_valid_d;
         pot0_q         <= pot0_d;
         pot1_q         <= pot1_d;
         pot2_q         <= pot2_d;
         overrun_q      <= overrun_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign start_cnv    = start_cnv_q;
   assign channel      = channel_q;
   assign audio_sample = audio_sample_q;
   assign audio_valid  = audio_valid_q;
   assign pot0         = pot0_q;
   assign pot1         = pot1_q;
   assign pot2         = pot2_q;
   assign overrun      = overrun_q;
   assign timeout_err  = timeout_err_q;

endmodule
